iq_aim_sequencer: RTL

- Programmable q-axis current setpoint scheduler. It replaces the free-running toggle that currently drives iq_aim into foc_top.
- Steps through a table of NSEG segments. Each segment has a target, a ramp slope and a hold time.
- Advances once per control period, on the en_idq pulse from foc_top.
- Monitors the measured iq for sustained overcurrent and forces iq_aim to 0 on a fault.

---
 rtl/iq_aim_sequencer_pkg.sv | 24 ++
 rtl/iq_aim_sequencer_if.sv | 42 ++++
 rtl/iq_limit_monitor.sv | 45 ++++
 rtl/iq_aim_sequencer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/iq_aim_sequencer_pkg.sv
// Shared types and widths for the iq_aim setpoint sequencer.
//   state_t : sequencer FSM states
//   seg_t   : one profile segment (target, ramp step, hold periods)
package foc_seq_pkg;

    localparam int IQ_W   = 16;
    localparam int STEP_W = 15;
    localparam int HOLD_W = 16;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    typedef struct packed {
        logic signed [IQ_W-1:0] target;
        logic [STEP_W-1:0]      step;
        logic [HOLD_W-1:0]      hold;
    } seg_t;

endpackage

// File: rtl/iq_aim_sequencer_if.sv
// Signal bundle between foc_top-side logic and the iq_aim sequencer.
//   cfg_*        : segment table write port
//   start/stop   : profile control pulses, loop is a level
//   en_idq, iq   : control-period strobe and measured q-axis current
//   iq_aim, busy, seg_idx, done, fault : sequencer outputs
// master = driver of control/config, slave = the sequencer.
interface iq_aim_sequencer_if
    import foc_seq_pkg::*;
#(
    parameter int NSEG = 4
);
    localparam int AW = $clog2(NSEG);

    logic                   cfg_we;
    logic [AW-1:0]          cfg_addr;
    logic signed [IQ_W-1:0] cfg_target;
    logic [STEP_W-1:0]      cfg_step;
    logic [HOLD_W-1:0]      cfg_hold;
    logic                   start;
    logic                   stop;
    logic                   loop;
    logic                   en_idq;
    logic signed [IQ_W-1:0] iq;
    logic signed [IQ_W-1:0] iq_aim;
    logic                   busy;
    logic [AW-1:0]          seg_idx;
    logic                   done;
    logic                   fault;

    modport master (
        output cfg_we, cfg_addr, cfg_target, cfg_step, cfg_hold,
        output start, stop, loop, en_idq, iq,
        input  iq_aim, busy, seg_idx, done, fault
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_target, cfg_step, cfg_hold,
        input  start, stop, loop, en_idq, iq,
        output iq_aim, busy, seg_idx, done, fault
    );

endinterface

// File: rtl/iq_limit_monitor.sv
// Sustained overcurrent detector on the measured q-axis current.
//   clk, rst : clock, async active-high reset
//   en_idq   : control-period strobe
//   iq       : signed measured current
//   arm      : monitor enabled (sequencer in RAMP/HOLD); counter clears when low
//   trip     : combinational, high on the en_idq that makes the count reach FAULT_CNT
module iq_limit_monitor
    import foc_seq_pkg::*;
#(
    parameter logic [IQ_W-1:0]  ILIMIT    = 16'd1000,
    parameter logic [CNT_W-1:0] FAULT_CNT = 8'd8
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_idq,
    input  logic signed [IQ_W-1:0] iq,
    input  logic                   arm,
    output logic                   trip
);

    logic [CNT_W-1:0] over_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [IQ_W:0]    iq_abs;
    logic             over;

    always_comb begin
        // 17-bit magnitude so -32768 becomes +32768 instead of wrapping
        iq_abs  = iq[IQ_W-1] ? ('0 - {iq[IQ_W-1], iq}) : {1'b0, iq};
        over    = iq_abs > {1'b0, ILIMIT};
        cnt_inc = (&over_cnt) ? over_cnt : over_cnt + CNT_W'(1);
        // Trip is combinational so the sequencer can override a same-cycle ramp update
        trip    = arm && en_idq && over && (cnt_inc >= FAULT_CNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            over_cnt <= '0;
        end else if (!arm) begin
            over_cnt <= '0;
        end else if (en_idq) begin
            over_cnt <= over ? cnt_inc : '0;
        end
    end

endmodule

// File: rtl/iq_aim_sequencer.sv
// Programmable q-axis current setpoint scheduler driving iq_aim into foc_top.
// Steps through NSEG segments (ramp to target, hold), once per en_idq, and
// forces iq_aim to 0 on sustained overcurrent.
//   clk, rst : clock, async active-high reset
//   sio      : iq_aim_sequencer_if slave (config, control, iq in; iq_aim/status out)
//
// state | meaning
// IDLE  | not running, iq_aim holds last value
// RAMP  | moving iq_aim toward the segment target by step per period
// HOLD  | at target, counting down hold periods
// FAULT | overcurrent trip, iq_aim forced to 0, fault set
module iq_aim_sequencer
    import foc_seq_pkg::*;
#(
    parameter int               NSEG      = 4,
    parameter logic [IQ_W-1:0]  ILIMIT    = 16'd1000,
    parameter logic [CNT_W-1:0] FAULT_CNT = 8'd8
)(
    input logic              clk,
    input logic              rst,
    iq_aim_sequencer_if.slave sio
);

    localparam int AW = $clog2(NSEG);

    seg_t                   tbl [NSEG];
    state_t                 state;
    logic [HOLD_W-1:0]      hold_cnt;
    logic signed [IQ_W-1:0] iq_aim_r;
    logic                   busy_r;
    logic [AW-1:0]          seg_idx_r;
    logic                   done_r;
    logic                   fault_r;

    seg_t                   seg_cur;
    logic signed [IQ_W:0]   diff;
    logic [IQ_W:0]          diff_abs;
    logic signed [IQ_W-1:0] ramp_next;
    logic                   ramp_hit;
    logic                   adv;
    logic                   last;
    logic                   arm;
    logic                   trip;

    assign sio.iq_aim  = iq_aim_r;
    assign sio.busy    = busy_r;
    assign sio.seg_idx = seg_idx_r;
    assign sio.done    = done_r;
    assign sio.fault   = fault_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSEG; i++) tbl[i] <= '0;
        end else if (sio.cfg_we) begin
            tbl[sio.cfg_addr] <= '{target: sio.cfg_target, step: sio.cfg_step, hold: sio.cfg_hold};
        end
    end

    always_comb begin
        seg_cur  = tbl[seg_idx_r];
        diff     = {seg_cur.target[IQ_W-1], seg_cur.target} - {iq_aim_r[IQ_W-1], iq_aim_r};
        diff_abs = diff[IQ_W] ? ('0 - diff) : diff;
        // Only step when strictly farther than one step away, so no overshoot
        // and the intermediate value always lies between iq_aim and target.
        if (seg_cur.step == '0 || diff_abs <= {2'b00, seg_cur.step})
            ramp_next = seg_cur.target;
        else if (diff[IQ_W])
            ramp_next = iq_aim_r - {1'b0, seg_cur.step};
        else
            ramp_next = iq_aim_r + {1'b0, seg_cur.step};
        ramp_hit = (ramp_next == seg_cur.target);
        adv      = ((state == RAMP) && ramp_hit && (seg_cur.hold == '0)) ||
                   ((state == HOLD) && (hold_cnt <= HOLD_W'(1)));
        last     = (seg_idx_r == AW'(NSEG - 1));
        arm      = (state == RAMP) || (state == HOLD);
    end

    iq_limit_monitor #(
        .ILIMIT    (ILIMIT),
        .FAULT_CNT (FAULT_CNT)
    ) u_mon (
        .clk    (clk),
        .rst    (rst),
        .en_idq (sio.en_idq),
        .iq     (sio.iq),
        .arm    (arm),
        .trip   (trip)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            iq_aim_r  <= '0;
            busy_r    <= 1'b0;
            seg_idx_r <= '0;
            done_r    <= 1'b0;
            fault_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (sio.stop) begin
                state    <= IDLE;
                iq_aim_r <= '0;
                busy_r   <= 1'b0;
                if (state == FAULT) fault_r <= 1'b0;
            end else if (trip) begin
                state    <= FAULT;
                iq_aim_r <= '0;
                busy_r   <= 1'b0;
                fault_r  <= 1'b1;
            end else if (sio.start) begin
                state     <= RAMP;
                seg_idx_r <= '0;
                busy_r    <= 1'b1;
                fault_r   <= 1'b0;
            end else if (sio.en_idq && arm) begin
                if (state == RAMP) begin
                    iq_aim_r <= ramp_next;
                    if (ramp_hit && seg_cur.hold != '0) begin
                        state    <= HOLD;
                        hold_cnt <= seg_cur.hold;
                    end
                end else begin
                    hold_cnt <= hold_cnt - HOLD_W'(1);
                end
                // Advance overrides the RAMP->HOLD move above when hold is 0
                if (adv) begin
                    if (!last) begin
                        seg_idx_r <= seg_idx_r + AW'(1);
                        state     <= RAMP;
                    end else if (sio.loop) begin
                        seg_idx_r <= '0;
                        state     <= RAMP;
                    end else begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
